pid_dispatcher: RTL
===================

// Module: pid_dispatcher
// PURPOSE
//  Read side of the receive-order PID FIFO: pops one PID byte at a time in arrival order.
//  Checks each byte's integrity and classifies it as token, data or handshake.
//  Hands the 4-bit PID to the matching downstream consumer over a valid/ready channel.
//  Sits between the receive PID FIFO and the token, data-path and handshake engines.
// PARAMETERS
//  ERR_W        8    width of saturating error counter
//  TIMEOUT      255  max cycles a channel may hold valid without ready before the PID is dropped (>=1)
//  TMO_W        8    width of timeout counter; must hold TIMEOUT
// PORTS
//  clk            in   1      system clock, rising edge
//  rst            in   1      asynchronous, active-high reset
//  fifo_empty     in   1      PID FIFO empty
//  fifo_r_data    in   8      PID FIFO head byte, valid while !fifo_empty
//  fifo_r_enable  out  1      pop strobe; head advances on the same clk edge
//  tok_valid/tok_ready  out/in 1  token channel (OUT, IN, SOF, SETUP)
//  dat_valid/dat_ready  out/in 1  data channel (DATA0, DATA1)
//  hsk_valid/hsk_ready  out/in 1  handshake channel (ACK, NAK, STALL)
//  pid_out        out  4      PID nibble for whichever channel is valid
//  pid_err        out  1      one-cycle pulse per dropped PID
//  err_count      out  ERR_W  dropped-PID total, saturates at all-ones
//  busy           out  1      high in any state other than IDLE
// BEHAVIOUR
//  - Reset (async, any state): FSM=IDLE; all *_valid, fifo_r_enable, pid_err = 0; pid_out=0; err_count=0; timeout cnt=0.
//    FIFO contents are not touched. Outputs are registered, except fifo_r_enable, which is combinational.
//  - IDLE: if !fifo_empty, then fifo_r_enable=1 this cycle, capture fifo_r_data into pid_q, go to CHECK. Otherwise stay.
//  - CHECK (1 cycle): the byte is invalid if pid_q[7:4] != ~pid_q[3:0] -> pid_err pulse, err_count+1, go to IDLE.
//    Class comes from pid_q[1:0]: 01 token, 11 data, 10 handshake.
//    00 (special/PRE/ERR/SPLIT/PING) and handshake 0110 (NYET) are unsupported -> drop as an error.
//    On a valid class: pid_out=pid_q[3:0], assert the one matching valid, clear the timeout cnt, go to SEND.
//  - SEND: hold valid and pid_out stable until ready; the transfer completes when valid&&ready.
//    Then deassert valid next cycle and go to IDLE. Exactly one *_valid is high at any time.
//  - Timeout: in SEND the cnt increments each cycle without ready. When cnt==TIMEOUT-1 and no ready:
//    drop the PID, deassert valid, pid_err pulse, err_count+1, go to IDLE.
//    This is the only case where valid falls without a transfer.
//  - Min latency: fifo pop -> valid = 2 clk. Min throughput: 1 PID per 3 clk with ready tied high.
//  - err_count: saturating; the increment at all-ones leaves the value unchanged. pid_err still pulses.
//  - Ready asserted while valid is low is ignored. fifo_empty is ignored outside IDLE.
// CONFIGURATION
//  PID_DISPATCH_TOGGLE_CHECK_EN defined:
//   - An exp_tgl flop (reset 0 = DATA0) is kept.
//   - In CHECK, a data PID with pid_q[3] != exp_tgl is dropped as an error and exp_tgl is unchanged.
//   - On a completed data transfer exp_tgl flips.
//   - On a completed SETUP token exp_tgl is forced to 0.
//  PID_DISPATCH_TOGGLE_CHECK_EN undefined:
//   - No toggle state; DATA0 and DATA1 are dispatched unconditionally.
// STRUCTURE
//  - Shared package usb_pid_pkg:
//   - pid_e enum (4-bit PID codes);
//   - pid_class_e {CLS_TOK, CLS_DAT, CLS_HSK, CLS_BAD};
//   - function pid_classify(logic [7:0]) returning pid_class_e, with the integrity and support checks.
//  - Local state enum {IDLE, CHECK, SEND}.
//  - No sub-module: one FSM, the timeout counter and the error counter.
// TESTING
//  1. FIFO gives 0xE1 (OUT), tok_ready=1 -> tok_valid on the 2nd clk after the pop, pid_out=4'h1, one pop, no pid_err.
//  2. FIFO gives 0x5A (NAK) with hsk_ready low for 10 clk -> valid and pid_out=4'hA held stable for 10 clk, transfer on the 11th.
//  3. FIFO gives 0x12 (corrupt), then 0xD2 (ACK) -> one pid_err pulse, err_count=1, then hsk_valid with pid_out=4'h2.
//  4. TIMEOUT=4, 0xC3 (DATA0), dat_ready=0 -> dat_valid high 4 clk then low, pid_err pulse, err_count=1, FSM back to IDLE.
//  5. TOGGLE_CHECK_EN: DATA0, DATA0, DATA1 -> 1st and 3rd dispatched, 2nd dropped (err_count=1). Undefined: all 3 dispatched.
//  6. rst pulse mid-SEND -> all valids 0 and err_count=0 immediately (async). After release, the next FIFO byte is popped normally.

Source files
------------

// File: rtl/pid_dispatcher_pkg.sv
// Shared USB PID definitions: PID codes, dispatch classes and the byte classifier.
package usb_pid_pkg;

   localparam int unsigned PID_W  = 4;
   localparam int unsigned BYTE_W = 8;

   typedef enum logic [3:0] {
      PID_RSVD  = 4'h0,
      PID_OUT   = 4'h1,
      PID_ACK   = 4'h2,
      PID_DATA0 = 4'h3,
      PID_PING  = 4'h4,
      PID_SOF   = 4'h5,
      PID_NYET  = 4'h6,
      PID_DATA2 = 4'h7,
      PID_SPLIT = 4'h8,
      PID_IN    = 4'h9,
      PID_NAK   = 4'hA,
      PID_DATA1 = 4'hB,
      PID_PRE   = 4'hC,
      PID_SETUP = 4'hD,
      PID_STALL = 4'hE,
      PID_MDATA = 4'hF
   } pid_e;

   typedef enum logic [1:0] {
      CLS_TOK,
      CLS_DAT,
      CLS_HSK,
      CLS_BAD
   } pid_class_e;

   // Integrity check (upper nibble is the complement of the lower), then class by low bits.
   function automatic pid_class_e pid_classify(input logic [BYTE_W-1:0] b);
      pid_class_e cls;
      cls = CLS_BAD;
      if (b[7:4] == ~b[3:0]) begin
         case (b[1:0])
            2'b01:   cls = CLS_TOK;
            2'b11:   cls = CLS_DAT;
            2'b10:   cls = (b[3:0] == 4'(PID_NYET)) ? CLS_BAD : CLS_HSK;
            default: cls = CLS_BAD;
         endcase
      end
      return cls;
   endfunction

endpackage

// File: rtl/pid_dispatcher_if.sv
// FIFO read port and the three downstream valid/ready channels of the PID dispatcher.
interface pid_dispatcher_if #(
   parameter int unsigned ERR_W = 8
);
   import usb_pid_pkg::*;

   logic                fifo_empty;
   logic [BYTE_W-1:0]   fifo_r_data;
   logic                fifo_r_enable;
   logic                tok_valid;
   logic                tok_ready;
   logic                dat_valid;
   logic                dat_ready;
   logic                hsk_valid;
   logic                hsk_ready;
   logic [PID_W-1:0]    pid_out;
   logic                pid_err;
   logic [ERR_W-1:0]    err_count;
   logic                busy;

   modport master (
      input  fifo_empty, fifo_r_data, tok_ready, dat_ready, hsk_ready,
      output fifo_r_enable, tok_valid, dat_valid, hsk_valid, pid_out, pid_err, err_count, busy
   );

   modport slave (
      output fifo_empty, fifo_r_data, tok_ready, dat_ready, hsk_ready,
      input  fifo_r_enable, tok_valid, dat_valid, hsk_valid, pid_out, pid_err, err_count, busy
   );

endinterface

// File: rtl/pid_dispatcher.sv
// PID dispatcher: pops PID bytes from the receive FIFO, validates and classifies them,
// and hands the nibble to the token, data or handshake channel. Stalled channels time out.
// Optional DATA0/DATA1 sequence checking is enabled with PID_DISPATCH_TOGGLE_CHECK_EN.
module pid_dispatcher
   import usb_pid_pkg::*;
#(
   parameter int unsigned ERR_W   = 8,
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned TMO_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   pid_dispatcher_if.master bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] CHECK = 2'd1;
   localparam logic [1:0] SEND  = 2'd2;

   logic [1:0]        state_q,   state_d;
   logic [BYTE_W-1:0] pid_q,     pid_d;
   logic [PID_W-1:0]  pid_out_q, pid_out_d;
   logic              tok_v_q,   tok_v_d;
   logic              dat_v_q,   dat_v_d;
   logic              hsk_v_q,   hsk_v_d;
   logic [TMO_W-1:0]  tmo_q,     tmo_d;
   logic [ERR_W-1:0]  err_q,     err_d;
   logic              perr_q,    perr_d;
   logic              busy_q,    busy_d;
`ifdef PID_DISPATCH_TOGGLE_CHECK_EN
   logic              tgl_q,     tgl_d;
`endif

   logic              fifo_re_c;
   logic              xfer_c;
   logic              drop_c;
   pid_class_e        cls_c;

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         pid_q     <= '0;
         pid_out_q <= '0;
         tok_v_q   <= 1'b0;
         dat_v_q   <= 1'b0;
         hsk_v_q   <= 1'b0;
         tmo_q     <= '0;
         err_q     <= '0;
         perr_q    <= 1'b0;
         busy_q    <= 1'b0;
`ifdef PID_DISPATCH_TOGGLE_CHECK_EN
         tgl_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         pid_q     <= pid_d;
         pid_out_q <= pid_out_d;
         tok_v_q   <= tok_v_d;
         dat_v_q   <= dat_v_d;
         hsk_v_q   <= hsk_v_d;
         tmo_q     <= tmo_d;
         err_q     <= err_d;
         perr_q    <= perr_d;
         busy_q    <= busy_d;
`ifdef PID_DISPATCH_TOGGLE_CHECK_EN
         tgl_q     <= tgl_d;
`endif
      end
   end

   // Next-state logic: pop, classify, dispatch, time out, count drops.
   always_comb begin
      state_d   = state_q;
      pid_d     = pid_q;
      pid_out_d = pid_out_q;
      tok_v_d   = tok_v_q;
      dat_v_d   = dat_v_q;
      hsk_v_d   = hsk_v_q;
      tmo_d     = tmo_q;
      err_d     = err_q;
      perr_d    = 1'b0;
`ifdef PID_DISPATCH_TOGGLE_CHECK_EN
      tgl_d     = tgl_q;
`endif
      fifo_re_c = 1'b0;
      drop_c    = 1'b0;
      cls_c     = pid_classify(pid_q);
      xfer_c    = (tok_v_q && bus.tok_ready) ||
                  (dat_v_q && bus.dat_ready) ||
                  (hsk_v_q && bus.hsk_ready);

`ifdef PID_DISPATCH_TOGGLE_CHECK_EN
      if (cls_c == CLS_DAT && pid_q[3] != tgl_q) begin
         cls_c = CLS_BAD;
      end
`endif

      case (state_q)
         IDLE: begin
            // Pop is blocked during reset so the FIFO is left untouched.
            if (!bus.fifo_empty && !rst) begin
               fifo_re_c = 1'b1;
               pid_d     = bus.fifo_r_data;
               state_d   = CHECK;
            end
         end
         CHECK: begin
            tmo_d = '0;
            case (cls_c)
               CLS_TOK: tok_v_d = 1'b1;
               CLS_DAT: dat_v_d = 1'b1;
               CLS_HSK: hsk_v_d = 1'b1;
               default: drop_c  = 1'b1;
            endcase
            if (drop_c) begin
               state_d = IDLE;
            end else begin
               pid_out_d = pid_q[PID_W-1:0];
               state_d   = SEND;
            end
         end
         SEND: begin
            if (xfer_c) begin
`ifdef PID_DISPATCH_TOGGLE_CHECK_EN
               if (dat_v_q) begin
                  tgl_d = ~tgl_q;
               end else if (tok_v_q && pid_out_q == 4'(PID_SETUP)) begin
                  tgl_d = 1'b0;
               end
`endif
               tok_v_d = 1'b0;
               dat_v_d = 1'b0;
               hsk_v_d = 1'b0;
               state_d = IDLE;
            end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
               tok_v_d = 1'b0;
               dat_v_d = 1'b0;
               hsk_v_d = 1'b0;
               drop_c  = 1'b1;
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         default: begin
            tok_v_d = 1'b0;
            dat_v_d = 1'b0;
            hsk_v_d = 1'b0;
            state_d = IDLE;
         end
      endcase

      // Every dropped PID pulses pid_err; the counter saturates at all-ones.
      if (drop_c) begin
         perr_d = 1'b1;
         if (err_q != '1) begin
            err_d = err_q + ERR_W'(1);
         end
      end

      busy_d = (state_d != IDLE);
   end

   assign bus.fifo_r_enable = fifo_re_c;
   assign bus.tok_valid     = tok_v_q;
   assign bus.dat_valid     = dat_v_q;
   assign bus.hsk_valid     = hsk_v_q;
   assign bus.pid_out       = pid_out_q;
   assign bus.pid_err       = perr_q;
   assign bus.err_count     = err_q;
   assign bus.busy          = busy_q;

endmodule
